// File: rtl/tbl_loader_if.sv
// Write/clear bus and table outputs of the coefficient table loader.
interface tbl_loader_if #(
  parameter int N_ENT = 32,
  parameter int EW    = 20,
  parameter int AW    = 5
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic                  wr_addr_en;
  logic [AW-1:0]         wr_addr;
  logic [EW-1:0]         wr_data;
  logic                  clr;
  logic [N_ENT*EW-1:0]   ins;
  logic [AW-1:0]         wr_ptr;
  logic                  full;
  logic                  busy;
  logic                  upd;

  modport master (
    output wr_valid, wr_addr_en, wr_addr, wr_data, clr,
    input  wr_ready, ins, wr_ptr, full, busy, upd
  );

  modport slave (
    input  wr_valid, wr_addr_en, wr_addr, wr_data, clr,
    output wr_ready, ins, wr_ptr, full, busy, upd
  );
endinterface

// File: rtl/tbl_loader.sv
// Table loader: accepts addressed or sequential entry writes, tracks which
// entries hold valid data, and clears the table with a one-entry-per-cycle
// sweep. The flattened table drives the downstream indexed lookup stage.
module tbl_loader #(
  parameter int N_ENT = 32,
  parameter int EW    = 20,
  parameter int AW    = 5
) (
  input  logic         clk,
  input  logic         rst,
  tbl_loader_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2,
    ST_CLEAR   = 2'd3
  } state_t;

  state_t                  state;
  logic [N_ENT-1:0][EW-1:0] tbl;
  logic [N_ENT-1:0]        bitmap;
  logic [N_ENT-1:0]        bitmap_nxt;
  logic [AW-1:0]           ptr;
  logic [AW-1:0]           swp;
  logic                    full_r;
  logic                    busy_r;
  logic                    upd_r;
  logic                    accept;
  logic [AW-1:0]           widx;

  // Ready depends only on the state and a pending clear, never on the write itself.
  assign bus.wr_ready = (state != ST_CLEAR) && !bus.clr;
  assign accept       = bus.wr_valid && bus.wr_ready;
  assign widx         = bus.wr_addr_en ? bus.wr_addr : ptr;

  assign bus.ins    = tbl;
  assign bus.wr_ptr = ptr;
  assign bus.full   = full_r;
  assign bus.busy   = busy_r;
  assign bus.upd    = upd_r;

  // Written-entry bitmap as it will look after this cycle's accept.
  always_comb begin
    bitmap_nxt = bitmap;
    if (accept) bitmap_nxt[widx] = 1'b1;
  end

  // Fill-level FSM with table storage, write pointer and clear sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_EMPTY;
      tbl    <= '0;
      bitmap <= '0;
      ptr    <= '0;
      swp    <= '0;
      full_r <= 1'b0;
      busy_r <= 1'b0;
      upd_r  <= 1'b0;
    end else begin
      upd_r <= accept;
      case (state)
        ST_CLEAR: begin
          tbl[swp] <= '0;
          swp      <= swp + AW'(1);
          if (swp == AW'(N_ENT - 1)) begin
            state  <= ST_EMPTY;
            busy_r <= 1'b0;
          end
        end
        default: begin
          if (bus.clr) begin
            state  <= ST_CLEAR;
            busy_r <= 1'b1;
            bitmap <= '0;
            full_r <= 1'b0;
            ptr    <= '0;
            swp    <= '0;
          end else begin
            if (accept) begin
              tbl[widx] <= bus.wr_data;
              if (!bus.wr_addr_en) ptr <= ptr + AW'(1);
            end
            bitmap <= bitmap_nxt;
            full_r <= &bitmap_nxt;
            if (&bitmap_nxt)      state <= ST_FULL;
            else if (|bitmap_nxt) state <= ST_PARTIAL;
            else                  state <= ST_EMPTY;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/tbl_loader.md
TBL_LOADER -- requirements
Module: tbl_loader

Interface
REQ-001 The block SHALL use one clock and asynchronous active-high reset: clk input 1 (all state on rising edge), then rst input 1 (asynchronous, active-high, clears all state).
REQ-002 Parameter N_ENT, default 32: number of table entries.
REQ-003 Parameter EW, default 20: entry width in bits.
REQ-004 Parameter AW, default 5: entry index width; N_ENT SHALL equal 2**AW.
REQ-005 wr_valid input 1: write request.
REQ-006 wr_ready output 1: block can accept a write this cycle.
REQ-007 wr_addr_en input 1: 1 = addressed write at wr_addr; 0 = sequential write at internal pointer.
REQ-008 wr_addr input AW: target entry for addressed writes.
REQ-009 wr_data input EW: entry value.
REQ-010 clr input 1: single-cycle request to zero the whole table.
REQ-011 ins output N_ENT*EW: flattened table; entry i at bits [i*EW +: EW]; feeds the downstream indexed lookup stage.
REQ-012 wr_ptr output AW: current sequential write pointer.
REQ-013 full output 1: every entry written since the last reset or clear.
REQ-014 busy output 1: clear sweep in progress.
REQ-015 upd output 1: one-cycle pulse the cycle after any accepted write.

Function
REQ-016 The FSM SHALL have states EMPTY (no entry written), PARTIAL (some entries written), FULL (all entries written) and CLEAR (sweep in progress).
REQ-017 A per-entry written bitmap (N_ENT bits) SHALL track entry status; full = AND of bitmap; the state SHALL be EMPTY/PARTIAL/FULL per bitmap unless in CLEAR.
REQ-018 wr_ready SHALL be 1 when state != CLEAR and clr = 0, else 0; it SHALL NOT depend on wr_valid, wr_addr_en, wr_addr or wr_data.
REQ-019 Accept = wr_valid & wr_ready, sampled on the rising clk edge.
REQ-020 Addressed accept: entry[wr_addr] <= wr_data; bitmap[wr_addr] <= 1; wr_ptr unchanged.
REQ-021 Sequential accept: entry[wr_ptr] <= wr_data; bitmap[wr_ptr] <= 1; wr_ptr <= wr_ptr+1 modulo N_ENT (31 -> 0 wraps silently; entry 0 is overwritten on the next sequential write).
REQ-022 ins SHALL reflect an accepted write on the cycle after acceptance (latency 1); upd SHALL be 1 in that same cycle only.
REQ-023 Writes in FULL SHALL be accepted and overwrite entries; full SHALL stay 1.
REQ-024 clr = 1 with state != CLEAR SHALL enter CLEAR on the next edge, with a concurrent wr_valid dropped (wr_ready = 0), bitmap zeroed, full <= 0 and wr_ptr <= 0.
REQ-025 In CLEAR, a sweep counter SHALL zero one entry per cycle, entries 0 to N_ENT-1, taking N_ENT cycles; busy = 1 throughout; on the cycle after entry N_ENT-1 is zeroed the state SHALL be EMPTY and busy = 0.
REQ-026 clr asserted during CLEAR SHALL be ignored; the sweep SHALL NOT restart.
REQ-027 Entries not yet swept during CLEAR SHALL keep their old value on ins until swept.
REQ-028 Storage SHALL NOT update without an accept or a sweep step; ins SHALL be driven directly from flops (no combinational path from inputs).

Reset
REQ-029 While rst = 1, asynchronously: all entries 0, ins = 0, bitmap 0, state EMPTY, wr_ptr 0, full 0, busy 0, upd 0, sweep counter 0; wr_ready = 1 once rst deasserts and clr = 0.
REQ-030 rst during CLEAR SHALL abort the sweep and force full reset values.

Verification
REQ-031 Reset release, 32 sequential writes with data = 0x10000+i -> after last accept full = 1, wr_ptr = 0, ins[i*20 +: 20] = 0x10000+i for all i, upd pulses 32 times.
REQ-032 Addressed write addr 7 data 0xABCDE after reset -> next cycle ins[159:140] = 0xABCDE, wr_ptr = 0, full = 0, state PARTIAL.
REQ-033 From FULL, one sequential write data 0x00055 -> entry 0 = 0x00055, wr_ptr = 1, full stays 1.
REQ-034 From FULL, clr = 1 with wr_valid = 1 -> write dropped, wr_ready = 0 that cycle, busy = 1 for exactly 32 cycles, then ins = 0, full = 0, wr_ready = 1; a second clr mid-sweep does not extend it.
REQ-035 rst pulse at sweep cycle 10 -> all outputs at reset values immediately, no remaining sweep activity after release.
REQ-036 Random mix of addressed/sequential writes with a stalled wr_valid, checked against a reference table model each cycle -> ins, wr_ptr and full match.
